// File: rtl/lcm_unit.sv
// lcm_unit: LCM(a,b) = (a/g)*b from a GCD result, via a W-cycle restoring
// divider followed by a W-cycle shift-add multiplier.
// Ports: clk, rst_n (async, active low); in_valid/in_ready with a_in,
//   b_in, g_in (W bits, unsigned); out_valid/out_ready with lcm_out (2W)
//   and err (g_in was zero, lcm_out forced to 0).
module lcm_unit #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   input  logic [W-1:0]   g_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] lcm_out,
   output logic           err
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      MUL,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]  cnt;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_r;
   logic [W-1:0]   g_r;
   logic [W-1:0]   q;
   logic [W:0]     rem;
   logic [W:0]     rem_sh;
   logic [W:0]     rem_sub;
   logic           take;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_nx;
   logic [W:0]     sum;
   logic [2*W-1:0] lcm_q;
   logic           err_q;
   logic           last;

   assign last = (cnt == LAST);

   // Divider step: a is consumed MSB first from a left-shifting copy, so
   // the quotient bit for a[W-1-i] lands in q's LSB and ends up in place.
   assign rem_sh  = (rem << 1) | {{W{1'b0}}, a_sh[W-1]};
   assign rem_sub = rem_sh - {1'b0, g_r};
   assign take    = (rem_sh >= {1'b0, g_r});

   // Multiplier step: add b into the upper half, then shift right with
   // the carry moving into the top bit of the 2W accumulator.
   assign sum    = {1'b0, acc[2*W-1:W]} + (q[0] ? {1'b0, b_r} : '0);
   assign acc_nx = {sum, acc[W-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = (g_in == '0) ? DONE : DIV;
            end
         end
         DIV: begin
            if (last) begin
               state_nx = MUL;
            end
         end
         MUL: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         a_sh  <= '0;
         b_r   <= '0;
         g_r   <= '0;
         q     <= '0;
         rem   <= '0;
         acc   <= '0;
         lcm_q <= '0;
         err_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a_in;
                  b_r   <= b_in;
                  g_r   <= g_in;
                  q     <= '0;
                  rem   <= '0;
                  acc   <= '0;
                  cnt   <= '0;
                  lcm_q <= '0;
                  err_q <= (g_in == '0);
               end
            end
            DIV: begin
               rem  <= take ? rem_sub : rem_sh;
               q    <= {q[W-2:0], take};
               a_sh <= a_sh << 1;
               cnt  <= last ? '0 : cnt + 1'b1;
            end
            MUL: begin
               acc <= acc_nx;
               q   <= q >> 1;
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  lcm_q <= acc_nx;
               end
            end
            DONE: begin
               if (out_ready) begin
                  lcm_q <= '0;
                  err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign lcm_out = lcm_q;
   assign err     = err_q;

endmodule

// File: doc/lcm_unit.md
Name: lcm_unit

Overview:
- Consumes the result of the GCD core together with the operand pair that produced it, and computes LCM(a,b) = (a / g) * b.
- Arithmetic is sequential and multi-cycle: a W-cycle restoring divider is followed by a W-cycle shift-add multiplier, matching the datapath/controller style of the Multiplier project.
- Sits directly downstream of GCD, with a valid/ready handshake on each side.

Parameters:
W, 8, operand width in bits (a, b, g); result is 2W bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a_in/b_in/g_in valid (driven by GCD done path)
in_ready  output  1  unit can accept an operand set
a_in  input  W  operand a (unsigned)
b_in  input  W  operand b (unsigned)
g_in  input  W  gcd(a,b) from GCD core (unsigned)
out_valid  output  1  lcm_out/err valid
out_ready  input  1  downstream accepts result
lcm_out  output  2W  (a/g)*b, unsigned
err  output  1  g_in was zero; lcm_out forced to 0

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, lcm_out=0, err=0.
  - All internal registers are cleared.
  - An operation in progress is discarded with no output.
- States: IDLE, DIV, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge (accept edge T0): register a, b, g.
  - If g_in==0: go to DONE with err=1 and lcm_out=0. out_valid is visible 1 cycle after T0.
  - Otherwise: clear quotient/remainder/product and go to DIV with the iteration counter at 0.
- DIV (restoring division, MSB first, one quotient bit per cycle):
  - rem = {rem[W-2:0], a[W-1-i]}; if rem >= g then rem -= g and q[W-1-i]=1.
  - Remainder register is W+1 bits to avoid overflow.
  - After W iterations (counter==W-1 on the final iteration) go to MUL.
  - The final remainder is discarded: if g does not divide a, the result is floor(a/g)*b with no flag.
- MUL (shift-add, LSB of q first):
  - If q[0]==1, add b into the upper half of the 2W-bit accumulator; then shift the accumulator and q right by 1.
  - The final carry is kept inside the 2W width.
  - After W iterations go to DONE.
  - lcm_out = product, err=0.
- Latency (g != 0): DIV occupies W edges, MUL occupies W edges. out_valid rises 2W cycles after T0 (16 cycles for W=8), independent of operand values.
- DONE:
  - out_valid=1, in_ready=0.
  - lcm_out and err are held stable until out_valid && out_ready at an edge; then go to IDLE and clear out_valid.
  - out_ready may already be high on entry, in which case DONE lasts exactly 1 cycle.
- in_ready is 1 only in IDLE.
  - in_valid outside IDLE is ignored; the upstream must hold it.
  - Minimum spacing between accepts is 2W+2 cycles for g!=0.
- Zero operands: a==0 or b==0 with g!=0 gives lcm_out=0, err=0, normal latency.
- Maximum result: (2^W-1)^2 fits in 2W bits; no overflow is possible.
- Result is taken from registers only; no combinational path exists from in_* to out_*.

Test Plan:
1. Reset then a=12, b=18, g=6 → lcm_out=36, err=0; out_valid rises exactly 16 cycles after the accept edge; in_ready=0 throughout.
2. a=255, b=255, g=1 → lcm_out=65025 (0xFE01), err=0. Also a=0, b=9, g=9 → lcm_out=0, err=0, same 16-cycle latency.
3. g=0 (a=5, b=7) → out_valid 1 cycle after accept, err=1, lcm_out=0; next op a=4, b=6, g=2 gives 12 with err=0.
4. Backpressure: a=21, b=6, g=3, hold out_ready=0 for 5 cycles after out_valid → lcm_out=42 stable, in_ready=0 with in_valid held high and a new operand set present; accepted only in the cycle after the out handshake.
5. Reset mid-DIV: accept a=100, b=10, g=10, pulse rst_n low at cycle 4 (asynchronous, off-edge) → outputs clear immediately, no out_valid ever produced; after release, a=8, b=12, g=4 → 24.
6. Back-to-back: in_valid held high with 3 sets ((6,4,2)→12, (9,6,3)→18, (7,5,1)→35), out_ready tied 1 → results in order, each accept 2W+2=18 cycles apart.
